// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU control words,
// branch-type encoding and the ID/EX control bundle.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned IMM16_W = 16;

  // Opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [OP_W-1:0] FN_ADD   = 6'b100000;
  localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUB   = 6'b100010;
  localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
  localparam logic [OP_W-1:0] FN_AND   = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR    = 6'b100101;
  localparam logic [OP_W-1:0] FN_XOR   = 6'b100110;
  localparam logic [OP_W-1:0] FN_SLT   = 6'b101010;

  // ALU control: {invert B + carry-in, op[2:0]}
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_XNOR = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1011;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_t;

  typedef struct packed {
    logic [ALU_W-1:0] alu_control;
    logic             alu_src;
    logic [XLEN-1:0]  imm;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    branch_t          branch;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [XLEN-1:0] sext16(input logic [IMM16_W-1:0] v);
    return {{(XLEN-IMM16_W){v[IMM16_W-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [IMM16_W-1:0] v);
    return {{(XLEN-IMM16_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// IF/ID-to-ID/EX bus: instruction + hazard controls in, EX control bundle out.
// master: drives the ID side (fetch/hazard unit); slave: the decode stage.
interface alu_decode_stage_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic [31:0]      id_instr;
  logic             id_valid;
  logic             stall;
  logic             flush;

  logic [3:0]       ex_alu_control;
  logic             ex_alu_src;
  logic [31:0]      ex_imm;
  logic             ex_reg_write;
  logic             ex_reg_dst;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_mem_to_reg;
  logic [1:0]       ex_branch;
  logic             ex_valid;
  logic             ex_illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output id_instr, id_valid, stall, flush,
    input  ex_alu_control, ex_alu_src, ex_imm, ex_reg_write, ex_reg_dst,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_valid,
           ex_illegal, illegal_count
  );

  modport slave (
    input  id_instr, id_valid, stall, flush,
    output ex_alu_control, ex_alu_src, ex_imm, ex_reg_write, ex_reg_dst,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_valid,
           ex_illegal, illegal_count
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: instr -> ID/EX control bundle + illegal flag.
// Ports: instr (32b in), ctrl_c (control struct out), illegal_c (undecodable out).
// R-type and illegal encodings carry imm=0; illegal encodings decode to a bubble.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output id_ex_ctrl_t     ctrl_c,
  output logic            illegal_c
);

  logic [OP_W-1:0]    opcode;
  logic [OP_W-1:0]    funct;
  logic [IMM16_W-1:0] imm16;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];

  always_comb begin
    ctrl_c    = CTRL_BUBBLE;
    illegal_c = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        unique case (funct)
          FN_ADD, FN_ADDU: ctrl_c.alu_control = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl_c.alu_control = ALU_SUB;
          FN_AND:          ctrl_c.alu_control = ALU_AND;
          FN_OR:           ctrl_c.alu_control = ALU_OR;
          FN_XOR:          ctrl_c.alu_control = ALU_XOR;
          FN_SLT:          ctrl_c.alu_control = ALU_SLT;
          default: begin
            ctrl_c    = CTRL_BUBBLE;
            illegal_c = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        unique case (opcode)
          OP_ADDI, OP_ADDIU: begin
            ctrl_c.alu_control = ALU_ADD;
            ctrl_c.imm         = sext16(imm16);
          end
          OP_SLTI: begin
            ctrl_c.alu_control = ALU_SLT;
            ctrl_c.imm         = sext16(imm16);
          end
          OP_ANDI: begin
            ctrl_c.alu_control = ALU_AND;
            ctrl_c.imm         = zext16(imm16);
          end
          OP_XORI: begin
            ctrl_c.alu_control = ALU_XOR;
            ctrl_c.imm         = zext16(imm16);
          end
          OP_ORI: begin
            ctrl_c.alu_control = ALU_OR;
            ctrl_c.imm         = zext16(imm16);
          end
          default: begin
            // lui: rs is $0, so OR-ing the shifted immediate yields it unchanged
            ctrl_c.alu_control = ALU_OR;
            ctrl_c.imm         = {imm16, 16'h0000};
          end
        endcase
      end
      OP_LW: begin
        ctrl_c.alu_control = ALU_ADD;
        ctrl_c.alu_src     = 1'b1;
        ctrl_c.imm         = sext16(imm16);
        ctrl_c.reg_write   = 1'b1;
        ctrl_c.mem_read    = 1'b1;
        ctrl_c.mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        ctrl_c.alu_control = ALU_ADD;
        ctrl_c.alu_src     = 1'b1;
        ctrl_c.imm         = sext16(imm16);
        ctrl_c.mem_write   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        // Compare by subtraction; EX resolves the branch from ALU zero
        ctrl_c.alu_control = ALU_SUB;
        ctrl_c.imm         = sext16(imm16);
        ctrl_c.branch      = (opcode == OP_BEQ) ? BR_EQ : BR_NE;
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage + ID/EX control register with flush > stall > load priority,
// and a saturating count of illegal instructions actually loaded into EX.
// Ports: clk, reset_n (async active-low), bus (alu_decode_stage_if.slave):
//   in  id_instr/id_valid/stall/flush; out ex_* control bundle, illegal_count.
module alu_decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              reset_n,
  alu_decode_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  id_ex_ctrl_t      dec_ctrl_c;
  logic             dec_illegal_c;

  id_ex_ctrl_t      ex_ctrl_q,    ex_ctrl_d;
  logic             ex_valid_q,   ex_valid_d;
  logic             ex_illegal_q, ex_illegal_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             load_c;

  alu_ctrl_decode u_dec (
    .instr     (bus.id_instr),
    .ctrl_c    (dec_ctrl_c),
    .illegal_c (dec_illegal_c)
  );

  assign load_c = !bus.flush && !bus.stall;

  // Next ID/EX contents: flush -> bubble, stall -> hold, else decode or bubble
  always_comb begin
    ex_ctrl_d    = ex_ctrl_q;
    ex_valid_d   = ex_valid_q;
    ex_illegal_d = ex_illegal_q;
    cnt_d        = cnt_q;
    if (bus.flush) begin
      ex_ctrl_d    = CTRL_BUBBLE;
      ex_valid_d   = 1'b0;
      ex_illegal_d = 1'b0;
    end else if (!bus.stall) begin
      if (bus.id_valid) begin
        ex_ctrl_d    = dec_ctrl_c;
        ex_valid_d   = 1'b1;
        ex_illegal_d = dec_illegal_c;
      end else begin
        ex_ctrl_d    = CTRL_BUBBLE;
        ex_valid_d   = 1'b0;
        ex_illegal_d = 1'b0;
      end
    end
    if (load_c && bus.id_valid && dec_illegal_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ID/EX register and illegal counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_valid_q   <= ex_valid_d;
      ex_illegal_q <= ex_illegal_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.ex_alu_control = ex_ctrl_q.alu_control;
  assign bus.ex_alu_src     = ex_ctrl_q.alu_src;
  assign bus.ex_imm         = ex_ctrl_q.imm;
  assign bus.ex_reg_write   = ex_ctrl_q.reg_write;
  assign bus.ex_reg_dst     = ex_ctrl_q.reg_dst;
  assign bus.ex_mem_read    = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write   = ex_ctrl_q.mem_write;
  assign bus.ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
  assign bus.ex_branch      = ex_ctrl_q.branch;
  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_illegal     = ex_illegal_q;
  assign bus.illegal_count  = cnt_q;

endmodule
